// File: rtl/adder_arbiter_if.sv
// ============================================================================
// Module   : adder_arbiter_if
// Brief    : Request/response bundle between the requesters and the shared
//            adder arbiter. The op_count signal exists only when
//            ADDER_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_arbiter_if #(
    parameter int W = 16,
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           locked;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]    op_count;

    modport master (
        output req_valid, req_last, req_a, req_b,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, locked, op_count
    );
    modport slave (
        input  req_valid, req_last, req_a, req_b,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, locked, op_count
    );
`else
    modport master (
        output req_valid, req_last, req_a, req_b,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, locked
    );
    modport slave (
        input  req_valid, req_last, req_a, req_b,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, locked
    );
`endif
endinterface

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
// Module   : adder_arbiter
// Brief    : Shares one W-bit carry-lookahead adder between N requesters with
//            round-robin grant, chained multi-word adds (carry forwarded
//            between words of one owner) and a one-cycle registered response.
//            Optional macro ADDER_ARB_STATS_EN adds a saturating accept counter
//            (op_count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    adder_arbiter_if.slave  bus
);

    localparam int PW = $clog2(N);
    localparam int GS = 4;          // lookahead group size
    localparam int NG = W / GS;     // number of lookahead groups

    typedef enum logic [0:0] {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [PW-1:0]  r_owner, w_owner_nxt;
    logic [PW-1:0]  r_ptr, w_ptr_nxt;
    logic           r_carry, w_carry_nxt;

    logic [N-1:0]   w_grant;
    logic [PW-1:0]  w_sel;
    logic [PW-1:0]  w_idx;
    logic           w_found;
    logic           w_accept;

    logic [W-1:0]   w_op_a, w_op_b, w_sum;
    logic           w_cin, w_cout;
    logic [W-1:0]   w_g, w_p;
    logic [NG:0]    w_gc;

    logic [N-1:0]   r_rsp_valid;
    logic [W-1:0]   r_rsp_sum;
    logic           r_rsp_cout;

    // Grant: owner only while locked, otherwise first valid searching up from ptr
    always_comb begin
        w_grant = '0;
        w_sel   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_grant[r_owner] = 1'b1;
            w_sel            = r_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                w_idx = PW'((int'(r_ptr) + k) % N);
                if (!w_found && bus.req_valid[w_idx]) begin
                    w_grant[w_idx] = 1'b1;
                    w_sel          = w_idx;
                    w_found        = 1'b1;
                end
            end
        end
    end

    assign w_accept = |(bus.req_valid & w_grant);
    assign w_op_a   = bus.req_a[w_sel*W +: W];
    assign w_op_b   = bus.req_b[w_sel*W +: W];
    assign w_cin    = (r_state == ST_LOCKED) ? r_carry : 1'b0;

    // Carry-lookahead adder: 4-bit lookahead groups, group carries chained
    assign w_g     = w_op_a & w_op_b;
    assign w_p     = w_op_a ^ w_op_b;
    assign w_gc[0] = w_cin;

    for (genvar k = 0; k < NG; k++) begin : g_cla_grp
        logic [GS-1:0] w_gg, w_gp, w_car;
        assign w_gg     = w_g[k*GS +: GS];
        assign w_gp     = w_p[k*GS +: GS];
        assign w_car[0] = w_gc[k];
        assign w_car[1] = w_gg[0] | (w_gp[0] & w_gc[k]);
        assign w_car[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (&w_gp[1:0] & w_gc[k]);
        assign w_car[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (&w_gp[2:1] & w_gg[0])
                        | (&w_gp[2:0] & w_gc[k]);
        assign w_gc[k+1] = w_gg[3] | (w_gp[3] & w_gg[2]) | (&w_gp[3:2] & w_gg[1])
                         | (&w_gp[3:1] & w_gg[0]) | (&w_gp & w_gc[k]);
        assign w_sum[k*GS +: GS] = w_gp ^ w_car;
    end

    assign w_cout = w_gc[NG];

    // Next lock state, owner, round-robin pointer and forwarded carry
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_carry_nxt = r_carry;
        if (w_accept) begin
            w_ptr_nxt = PW'((int'(w_sel) + 1) % N);
            if (bus.req_last[w_sel]) begin
                w_state_nxt = ST_FREE;
                w_carry_nxt = 1'b0;
            end else begin
                w_state_nxt = ST_LOCKED;
                w_owner_nxt = w_sel;
                w_carry_nxt = w_cout;
            end
        end
    end

    // Control state register; reset abandons any chain in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FREE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    // Registered response: one-cycle valid pulse per accept, data held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept ? w_grant : '0;
            if (w_accept) begin
                r_rsp_sum  <= w_sum;
                r_rsp_cout <= w_cout;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.locked    = (r_state == ST_LOCKED);

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] r_op_count;

    // Saturating count of accepted operations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_accept && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign bus.op_count = r_op_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// Module   : tb_adder_arbiter
// Brief    : Directed, table-driven bench for adder_arbiter plus hand-written
//            sequences for chains, stalls and reset mid-chain. The stats block
//            is exercised when ADDER_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

    logic clk;
    logic rst;

    adder_arbiter_if #(.W(16), .N(4)) bus ();

    adder_arbiter #(.W(16), .N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ready;
        logic [3:0]  rvalid;
        logic        chk_data;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_word(input int r, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[r*16 +: 16] = a;
        bus.req_b[r*16 +: 16] = b;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;

        // Single op, overflow, search from a non-zero ptr with wrap, idle
        vt[0] = '{1'b1, 4'b0001, 4'b1111, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_0FFF,
                  4'b0001, 4'b0001, 1'b1, 16'h2233, 1'b0};
        vt[1] = '{1'b0, 4'b0100, 4'b1111, 64'h0000_FFFF_0000_0000, 64'h0000_0001_0000_0000,
                  4'b0100, 4'b0100, 1'b1, 16'h0000, 1'b1};
        vt[2] = '{1'b0, 4'b1011, 4'b1111, 64'h8000_0000_0005_0007, 64'h8000_0000_0005_0007,
                  4'b1000, 4'b1000, 1'b1, 16'h0000, 1'b1};
        vt[3] = '{1'b0, 4'b0110, 4'b1111, 64'h0000_0F00_00F0_0000, 64'h0000_0001_0010_0000,
                  4'b0010, 4'b0010, 1'b1, 16'h0100, 1'b0};
        vt[4] = '{1'b0, 4'b0000, 4'b1111, 64'h0, 64'h0,
                  4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0};
        // Round robin from reset: all four valid for eight cycles
        for (int j = 0; j < 8; j++) begin
            vt[5+j] = '{(j == 0), 4'b1111, 4'b1111,
                        64'h0004_0003_0002_0001, 64'h0400_0300_0200_0100,
                        4'(1 << (j % 4)), 4'(1 << (j % 4)), 1'b1,
                        16'(16'h0101 * ((j % 4) + 1)), 1'b0};
        end

        // Reset values
        do_reset();
        #1;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_sum",   32'(bus.rsp_sum),   32'h0);
        chk("reset_rsp_cout",  32'(bus.rsp_cout),  32'h0);
        chk("reset_locked",    32'(bus.locked),    32'h0);
        chk("reset_ready",     32'(bus.req_ready), 32'h0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].do_rst) do_reset();
            bus.req_valid = vt[i].valid;
            bus.req_last  = vt[i].last;
            bus.req_a     = vt[i].a;
            bus.req_b     = vt[i].b;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vt[i].ready));
            tick();
            chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vt[i].rvalid));
            if (vt[i].chk_data) begin
                chk($sformatf("v%0d_sum", i),  32'(bus.rsp_sum),  32'(vt[i].sum));
                chk($sformatf("v%0d_cout", i), 32'(bus.rsp_cout), 32'(vt[i].cout));
            end
        end
        bus.req_valid = '0;

        // 32-bit chain by requester 1 with requester 3 contending, owner stall
        do_reset();
        bus.req_valid = 4'b1010;
        bus.req_last  = 4'b1101;
        set_word(1, 16'hFFFF, 16'h0001);
        set_word(3, 16'h0007, 16'h0008);
        #1;
        chk("chain_w0_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        chk("chain_w0_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
        chk("chain_w0_sum",       32'(bus.rsp_sum),   32'h0000);
        chk("chain_w0_cout",      32'(bus.rsp_cout),  32'h1);
        chk("chain_locked",       32'(bus.locked),    32'h1);
        bus.req_valid = 4'b1000;
        #1;
        chk("chain_stall_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        chk("chain_stall_rsp_valid", 32'(bus.rsp_valid), 32'b0000);
        chk("chain_stall_locked",    32'(bus.locked),    32'h1);
        bus.req_valid = 4'b1010;
        bus.req_last  = 4'b1111;
        set_word(1, 16'h0000, 16'h0000);
        #1;
        chk("chain_w1_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        chk("chain_w1_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
        chk("chain_w1_sum",       32'(bus.rsp_sum),   32'h0001);
        chk("chain_w1_cout",      32'(bus.rsp_cout),  32'h0);
        chk("chain_unlocked",     32'(bus.locked),    32'h0);
        chk("chain_r3_ready",     32'(bus.req_ready), 32'b1000);
        tick();
        chk("chain_r3_rsp_valid", 32'(bus.rsp_valid), 32'b1000);
        chk("chain_r3_sum",       32'(bus.rsp_sum),   32'h000F);

        // Back-to-back chain words: carry forwarded on the very next cycle
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b1110;
        set_word(0, 16'hFFFF, 16'hFFFF);
        #1;
        chk("b2b_w0_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        chk("b2b_w0_sum",  32'(bus.rsp_sum),  32'hFFFE);
        chk("b2b_w0_cout", 32'(bus.rsp_cout), 32'h1);
        bus.req_last = 4'b1111;
        set_word(0, 16'h0001, 16'h0000);
        tick();
        chk("b2b_w1_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("b2b_w1_sum",       32'(bus.rsp_sum),   32'h0002);
        chk("b2b_w1_cout",      32'(bus.rsp_cout),  32'h0);
        chk("b2b_unlocked",     32'(bus.locked),    32'h0);
        bus.req_valid = '0;

        // Reset asserted while LOCKED(2)
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b1011;
        set_word(2, 16'hFFFF, 16'h0001);
        #1;
        chk("rstmid_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        chk("rstmid_locked_before", 32'(bus.locked), 32'h1);
        bus.req_valid = '0;
        rst = 1'b1;
        #1;
        chk("rstmid_async_locked",    32'(bus.locked),    32'h0);
        chk("rstmid_async_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_after_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rstmid_after_locked",    32'(bus.locked),    32'h0);
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b1111;
        set_word(2, 16'h0001, 16'h0001);
        #1;
        chk("rstmid_next_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        chk("rstmid_next_sum",  32'(bus.rsp_sum),  32'h0002);
        chk("rstmid_next_cout", 32'(bus.rsp_cout), 32'h0);
        bus.req_valid = '0;

`ifdef ADDER_ARB_STATS_EN
        do_reset();
        chk("stats_reset", 32'(bus.op_count), 32'h0);
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b1111;
        repeat (5) @(posedge clk);
        #1;
        bus.req_valid = '0;
        chk("stats_five", 32'(bus.op_count), 32'd5);
        bus.req_valid = 4'b0001;
        repeat (65535) @(posedge clk);
        #1;
        chk("stats_saturate", 32'(bus.op_count), 32'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = '0;
        chk("stats_hold", 32'(bus.op_count), 32'hFFFF);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one 16-bit carry-lookahead adder between four requesters with round-robin arbitration and a one-cycle registered response. It supports multi-word (chained) additions: a requester can hold the adder across consecutive words, and the carry-out of each word feeds the carry-in of the next. It sits between the requesting blocks and the adder datapath, and is the only path by which those blocks reach the adder.

## Interface
- `W`, 16: operand width per word; must match the adder width.
- `N`, 4: number of requesters; fixed at 4 in this release.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  N  per-requester operation request.
- `req_last`  in  N  marks the final word of a chain; 1 for single-word ops.
- `req_a`  in  N*W  operand A; requester i occupies bits [i*W +: W].
- `req_b`  in  N*W  operand B, same packing as `req_a`.
- `req_ready`  out  N  one-hot grant; accept occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  N  one-hot; identifies the requester that owns the current response.
- `rsp_sum`  out  W  registered sum.
- `rsp_cout`  out  1  registered carry-out.
- `locked`  out  1  high while a chain holds the adder.

## Operation
- **States**
  - FREE: no chain is in progress.
  - LOCKED(owner): a chain is in progress for requester `owner`.
- **Grant in FREE**
  - Grant goes to the first requester with `req_valid` high, searching upward from `ptr` and wrapping modulo N.
  - `req_ready` is combinational from `req_valid`, `ptr` and the lock state.
  - `req_ready` is all-zero when no requester is valid.
- **Grant in LOCKED**
  - `req_ready[owner] = 1` and every other `req_ready` bit is 0, regardless of `req_valid`.
- **On accept by requester i**
  - Compute `{cout, sum} = a_i + b_i + cin`.
  - `cin` is 0 in FREE and the stored `carry` register in LOCKED.
  - Register the result.
  - Set `carry <= cout`.
  - `ptr <= (i+1) mod N`.
  - If `req_last[i] = 0`, go to or stay in LOCKED(i).
  - If `req_last[i] = 1`, go to FREE and clear `carry` to 0.
- **While LOCKED with no accept**
  - `carry`, `ptr` and the lock state hold.
  - A chain may stall indefinitely; there is no timeout.
- **Response**
  - No backpressure: a requester must consume the response in the cycle `rsp_valid` is high.
- **Arithmetic**
  - Unsigned W-bit addition.
  - `rsp_cout` is bit W of the (W+1)-bit result.
  - Overflow is reported only through `rsp_cout`; no other flag is produced.
- **Reset values**
  - `rsp_valid = 0`, `rsp_sum = 0`, `rsp_cout = 0`, `locked = 0`.
  - Internal: `ptr = 0`, `carry = 0`, state FREE.
- **Boundary cases**
  - Reset asserted mid-chain: the chain is abandoned, state returns to FREE, and no partial response is produced after reset.
  - All N valid in the same cycle: exactly one grant, as selected by `ptr`.
  - `ptr` wraps from 3 to 0.
  - `req_valid[owner]` drops while LOCKED: the adder stays locked and the other requesters stay blocked.

## Timing
- **Latency:** an accept in cycle t gives `rsp_valid`, `rsp_sum` and `rsp_cout` in cycle t+1.
- **Throughput:** one operation per cycle, sustained within a chain and across requesters.
- **Response pulse:** `rsp_valid` is high for exactly one cycle per accept. It is zero in any cycle that follows a cycle with no accept.
- **`locked` timing:** `locked` reflects the registered state, so it rises in the cycle after the accept of a `req_last = 0` word.
- **Carry forwarding:** the stored carry is used by the owner's next accept, which can be the immediately following cycle.

## Configuration
- **`ADDER_ARB_STATS_EN` defined:** adds port `op_count  out  16`.
  - Counts accepts, incrementing by 1 per accept.
  - Saturates at 0xFFFF.
  - Reset value 0.
- **`ADDER_ARB_STATS_EN` undefined:** the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- **Single op:** reset, then requester 0 with a=0x1234, b=0x0FFF, last=1.
  - Cycle t: `req_ready` = 0001.
  - Cycle t+1: `rsp_valid` = 0001, `rsp_sum` = 0x2233, `rsp_cout` = 0.
- **Overflow:** requester 2 with a=0xFFFF, b=0x0001, last=1.
  - Response: `rsp_sum` = 0x0000, `rsp_cout` = 1.
- **Round-robin:** all four requesters valid for 8 cycles, every word last=1, `ptr` = 0 after reset.
  - Grant order: 0, 1, 2, 3, 0, 1, 2, 3.
- **32-bit chain with contention:** requester 1 sends word 0 (a=0xFFFF, b=0x0001, last=0) then word 1 (a=0x0000, b=0x0000, last=1), while requester 3 is continuously valid.
  - Responses: 0x0000 with cout=1, then 0x0001 with cout=0.
  - `req_ready[3]` stays 0 until the cycle after the last word is accepted.
- **Reset mid-chain:** assert `rst` while LOCKED(2), then release it.
  - `locked` = 0 and `rsp_valid` = 0 after reset.
  - Next op from requester 2 (a=0x0001, b=0x0001, last=1) gives 0x0002, which confirms the carry was cleared.
- **Stats build:** with `ADDER_ARB_STATS_EN` defined, issue 5 accepts.
  - `op_count` = 5.
  - Preload near saturation; `op_count` stays at 0xFFFF.
